// File: rtl/jtag_bus_master_pkg.sv
// jtag_bus_master_pkg: shared state encoding, timeout width and burst-length clamp
package jtag_bus_master_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_REQ, S_BEGIN, S_WDATA, S_END, S_RDATA, S_DONE
  } state_t;
  localparam int TO_W = 8;
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input int max_burst);
    return ({1'b0, len} > 9'(max_burst - 1)) ? 8'(max_burst - 1) : len;
  endfunction
endpackage

// File: rtl/jtag_bus_master_burst_buffer.sv
// jtag_burst_buffer: write-burst word store with fill pointer, drain index and flush
module jtag_burst_buffer #(
  parameter int DEPTH = 16,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_adv,
  output logic [31:0]   rd_data,
  output logic [AW:0]   wr_cnt,
  output logic [AW:0]   rd_idx
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt[AW-1:0]] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_cnt <= '0;
      rd_idx <= '0;
    end else begin
      wr_cnt <= wr_en ? wr_cnt + 1'b1 : wr_cnt;
      rd_idx <= rd_adv ? rd_idx + 1'b1 : rd_idx;
    end
  end
  assign rd_data = mem[rd_idx[AW-1:0]];
endmodule

// File: rtl/jtag_bus_master.sv
// jtag_bus_master: executes buffered write / streamed read bursts from the debug layer on the system bus
module jtag_bus_master
  import jtag_bus_master_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255,
  localparam int AW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1
) (
  input  logic        system_clock,
  input  logic        system_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [3:0]  cmd_byte_en,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        done,
  output logic        error,
  output logic        request_out,
  input  logic        grant_in,
  output logic [31:0] address_dataOUT,
  output logic [3:0]  byte_enablesOUT,
  output logic [7:0]  burstSizeOUT,
  output logic        read_n_writeOUT,
  output logic        begin_transactionOUT,
  output logic        end_transactionOUT,
  output logic        data_validOUT,
  output logic        busyOUT,
  input  logic [31:0] address_dataIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  input  logic        errorIN
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic write_q, write_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, rd_data;
  logic [7:0] len_q, len_d;
  logic [3:0] be_q, be_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [8:0] rcnt_q, rcnt_d;
  logic [AW:0] wr_cnt, rd_idx;
  logic watched, progress, timeout, wr_last, rd_last;
  jtag_burst_buffer #(.DEPTH(MAX_BURST)) u_buf (
    .clk(system_clock),
    .rst(system_reset),
    .flush(state_q == S_DONE),
    .wr_en(state_q == S_FILL && wdata_valid),
    .wr_data(wdata),
    .rd_adv(state_q == S_WDATA && !busyIN),
    .rd_data(rd_data),
    .wr_cnt(wr_cnt),
    .rd_idx(rd_idx)
  );
  assign wr_last  = 9'(wr_cnt) == {1'b0, len_q};
  assign rd_last  = 9'(rd_idx) == {1'b0, len_q};
  assign watched  = state_q inside {S_REQ, S_WDATA, S_RDATA};
  assign progress = (state_q == S_REQ && grant_in) || (state_q == S_WDATA && !busyIN) ||
                    (state_q == S_RDATA && data_validIN);
  assign timeout  = TIMEOUT != 0 && watched && !progress && cnt_q == TO_LAST;
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    len_d   = len_q;
    be_d    = be_q;
    err_d   = err_q;
    rcnt_d  = rdata_valid ? rcnt_q + 9'd1 : rcnt_q;
    cnt_d   = (!watched || progress) ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        write_d = cmd_write;
        addr_d  = cmd_addr & ~32'h3;
        len_d   = clamp_len(cmd_len, MAX_BURST);
        be_d    = cmd_byte_en;
        rcnt_d  = '0;
        state_d = cmd_write ? S_FILL : S_REQ;
      end
      S_FILL: state_d = (wdata_valid && wr_last) ? S_REQ : S_FILL;
      S_REQ: begin
        err_d   = err_q | timeout;
        state_d = timeout ? S_DONE : grant_in ? S_BEGIN : S_REQ;
      end
      S_BEGIN: begin
        err_d   = err_q | errorIN;
        state_d = !write_q ? S_RDATA : errorIN ? S_END : S_WDATA;
      end
      S_WDATA: begin
        err_d   = err_q | errorIN | timeout;
        state_d = (errorIN || timeout || (!busyIN && rd_last)) ? S_END : S_WDATA;
      end
      S_END: state_d = S_DONE;
      S_RDATA: begin
        err_d   = err_q | errorIN | timeout;
        state_d = (end_transactionIN || timeout) ? S_DONE : S_RDATA;
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      be_q    <= be_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end
  assign cmd_ready            = state_q == S_IDLE;
  assign wdata_ready          = state_q == S_FILL;
  assign rdata_valid          = state_q == S_RDATA && data_validIN && !errorIN && !err_q &&
                                rcnt_q <= {1'b0, len_q};
  assign rdata                = rdata_valid ? address_dataIN : '0;
  assign done                 = state_q == S_DONE;
  assign error                = state_q == S_DONE && err_q;
  assign request_out          = state_q inside {S_REQ, S_BEGIN, S_WDATA, S_RDATA, S_END};
  assign begin_transactionOUT = state_q == S_BEGIN;
  assign address_dataOUT      = state_q == S_BEGIN ? addr_q : state_q == S_WDATA ? rd_data : '0;
  assign byte_enablesOUT      = state_q == S_BEGIN ? be_q : '0;
  assign burstSizeOUT         = state_q == S_BEGIN ? len_q : '0;
  assign read_n_writeOUT      = state_q == S_BEGIN && !write_q;
  assign end_transactionOUT   = state_q == S_END;
  assign data_validOUT        = state_q == S_WDATA;
  assign busyOUT              = 1'b0;
endmodule

// File: tb/tb_jtag_bus_master.sv
// tb_jtag_bus_master: directed self-checking bench for jtag_bus_master
module tb_jtag_bus_master;
  logic system_clock = 0, system_reset = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0;
  logic [7:0] cmd_len = 0;
  logic [3:0] cmd_byte_en = 0;
  logic wdata_valid = 0, wdata_ready;
  logic [31:0] wdata = 0, rdata;
  logic rdata_valid, done, error, request_out, grant_in = 0;
  logic [31:0] address_dataOUT;
  logic [3:0] byte_enablesOUT;
  logic [7:0] burstSizeOUT;
  logic read_n_writeOUT, begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT;
  logic [31:0] address_dataIN = 0;
  logic end_transactionIN = 0, data_validIN = 0, busyIN = 0, errorIN = 0;
  int n_vec = 0, n_err = 0;
  jtag_bus_master #(.MAX_BURST(16), .TIMEOUT(8)) dut (
    .system_clock(system_clock), .system_reset(system_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_byte_en(cmd_byte_en),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .error(error),
    .request_out(request_out), .grant_in(grant_in),
    .address_dataOUT(address_dataOUT), .byte_enablesOUT(byte_enablesOUT),
    .burstSizeOUT(burstSizeOUT), .read_n_writeOUT(read_n_writeOUT),
    .begin_transactionOUT(begin_transactionOUT), .end_transactionOUT(end_transactionOUT),
    .data_validOUT(data_validOUT), .busyOUT(busyOUT),
    .address_dataIN(address_dataIN), .end_transactionIN(end_transactionIN),
    .data_validIN(data_validIN), .busyIN(busyIN), .errorIN(errorIN)
  );
  always #5 system_clock = ~system_clock;
  task automatic tick;
    @(posedge system_clock);
    #2;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] l);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_byte_en = 4'hF;
    tick;
    cmd_valid = 0;
  endtask
  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wdata_valid = 1; wdata = base + 32'(i);
      tick;
    end
    wdata_valid = 0;
  endtask
  task automatic grant;
    grant_in = 1;
    tick;
    grant_in = 0;
  endtask
  task automatic test_reset;
    system_reset = 1;
    tick; tick;
    system_reset = 0;
    #1;
    n_vec++; if ({cmd_ready, wdata_ready, rdata_valid, done, error, request_out, begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT, read_n_writeOUT} !== 11'b10000000000) begin n_err++; $display("FAIL reset_ctrl got=%b exp=%b", {cmd_ready, wdata_ready, rdata_valid, done, error, request_out, begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT, read_n_writeOUT}, 11'b10000000000); end
    n_vec++; if ({address_dataOUT, byte_enablesOUT, burstSizeOUT, rdata} !== 76'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {address_dataOUT, byte_enablesOUT, burstSizeOUT, rdata}); end
  endtask
  task automatic test_write;
    issue(1, 32'h100, 3);
    #1;
    n_vec++; if (wdata_ready !== 1'b1) begin n_err++; $display("FAIL w_fill_ready got=%b exp=1", wdata_ready); end
    fill(32'hA0, 4);
    wdata_valid = 1;
    #1;
    n_vec++; if ({request_out, wdata_ready} !== 2'b10) begin n_err++; $display("FAIL w_req got=%b exp=10", {request_out, wdata_ready}); end
    wdata_valid = 0;
    grant;
    #1;
    n_vec++; if ({begin_transactionOUT, read_n_writeOUT, data_validOUT, burstSizeOUT, byte_enablesOUT, address_dataOUT} !== {3'b100, 8'd3, 4'hF, 32'h100}) begin n_err++; $display("FAIL w_begin got=%h exp=%h", {begin_transactionOUT, read_n_writeOUT, data_validOUT, burstSizeOUT, byte_enablesOUT, address_dataOUT}, {3'b100, 8'd3, 4'hF, 32'h100}); end
    tick;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if ({data_validOUT, address_dataOUT} !== {1'b1, 32'hA0 + 32'(i)}) begin n_err++; $display("FAIL w_data%0d got=%h exp=%h", i, {data_validOUT, address_dataOUT}, {1'b1, 32'hA0 + 32'(i)}); end
      tick;
    end
    #1;
    n_vec++; if ({end_transactionOUT, data_validOUT, request_out} !== 3'b101) begin n_err++; $display("FAIL w_end got=%b exp=101", {end_transactionOUT, data_validOUT, request_out}); end
    tick; #1;
    n_vec++; if ({done, error, request_out} !== 3'b100) begin n_err++; $display("FAIL w_done got=%b exp=100", {done, error, request_out}); end
    tick; #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL w_idle got=%b exp=1", cmd_ready); end
  endtask
  task automatic test_busy;
    logic [31:0] exp_d [6] = '{32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA2, 32'hA3};
    logic b [6] = '{0, 1, 1, 0, 0, 0};
    issue(1, 32'h100, 3);
    fill(32'hA0, 4);
    grant;
    tick;
    for (int i = 0; i < 6; i++) begin
      busyIN = b[i];
      #1;
      n_vec++; if ({data_validOUT, address_dataOUT} !== {1'b1, exp_d[i]}) begin n_err++; $display("FAIL busy_data%0d got=%h exp=%h", i, {data_validOUT, address_dataOUT}, {1'b1, exp_d[i]}); end
      tick;
    end
    busyIN = 0;
    #1;
    n_vec++; if (end_transactionOUT !== 1'b1) begin n_err++; $display("FAIL busy_end got=%b exp=1", end_transactionOUT); end
    tick; #1;
    n_vec++; if ({done, error} !== 2'b10) begin n_err++; $display("FAIL busy_done got=%b exp=10", {done, error}); end
    tick;
  endtask
  task automatic test_read;
    logic [31:0] w [3] = '{32'h11, 32'h22, 32'h33};
    logic v [3] = '{1, 1, 0};
    issue(0, 32'h200, 1);
    #1;
    n_vec++; if ({request_out, cmd_ready} !== 2'b10) begin n_err++; $display("FAIL r_req got=%b exp=10", {request_out, cmd_ready}); end
    grant;
    #1;
    n_vec++; if ({begin_transactionOUT, read_n_writeOUT, burstSizeOUT, address_dataOUT} !== {2'b11, 8'd1, 32'h200}) begin n_err++; $display("FAIL r_begin got=%h exp=%h", {begin_transactionOUT, read_n_writeOUT, burstSizeOUT, address_dataOUT}, {2'b11, 8'd1, 32'h200}); end
    tick;
    for (int i = 0; i < 3; i++) begin
      data_validIN = 1; address_dataIN = w[i];
      #1;
      n_vec++; if ({rdata_valid, rdata} !== {v[i], v[i] ? w[i] : 32'h0}) begin n_err++; $display("FAIL r_word%0d got=%h exp=%h", i, {rdata_valid, rdata}, {v[i], v[i] ? w[i] : 32'h0}); end
      tick;
    end
    data_validIN = 0; end_transactionIN = 1;
    #1;
    n_vec++; if (rdata_valid !== 1'b0) begin n_err++; $display("FAIL r_endcyc got=%b exp=0", rdata_valid); end
    tick;
    end_transactionIN = 0;
    #1;
    n_vec++; if ({done, error, request_out} !== 3'b100) begin n_err++; $display("FAIL r_done got=%b exp=100", {done, error, request_out}); end
    tick;
  endtask
  task automatic test_read_error;
    issue(0, 32'h300, 1);
    grant;
    tick;
    data_validIN = 1; errorIN = 1; end_transactionIN = 1; address_dataIN = 32'h44;
    tick;
    errorIN = 0; end_transactionIN = 0;
    #1;
    n_vec++; if ({done, error, rdata_valid} !== 3'b110) begin n_err++; $display("FAIL re_done got=%b exp=110", {done, error, rdata_valid}); end
    data_validIN = 0;
    tick; #1;
    n_vec++; if ({cmd_ready, error} !== 2'b10) begin n_err++; $display("FAIL re_idle got=%b exp=10", {cmd_ready, error}); end
  endtask
  task automatic test_timeout;
    issue(0, 32'h400, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++; if ({request_out, begin_transactionOUT, done} !== 3'b100) begin n_err++; $display("FAIL to_wait%0d got=%b exp=100", i, {request_out, begin_transactionOUT, done}); end
      tick;
    end
    #1;
    n_vec++; if ({request_out, begin_transactionOUT, done, error} !== 4'b0011) begin n_err++; $display("FAIL to_done got=%b exp=0011", {request_out, begin_transactionOUT, done, error}); end
    tick; #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL to_idle got=%b exp=1", cmd_ready); end
  endtask
  task automatic test_write_error;
    issue(1, 32'h500, 3);
    fill(32'hE0, 4);
    grant;
    tick;
    errorIN = 1;
    #1;
    n_vec++; if ({data_validOUT, address_dataOUT} !== {1'b1, 32'hE0}) begin n_err++; $display("FAIL we_data got=%h exp=%h", {data_validOUT, address_dataOUT}, {1'b1, 32'hE0}); end
    tick;
    errorIN = 0;
    #1;
    n_vec++; if ({end_transactionOUT, data_validOUT} !== 2'b10) begin n_err++; $display("FAIL we_end got=%b exp=10", {end_transactionOUT, data_validOUT}); end
    tick; #1;
    n_vec++; if ({done, error} !== 2'b11) begin n_err++; $display("FAIL we_done got=%b exp=11", {done, error}); end
    tick;
  endtask
  task automatic test_clamp;
    issue(0, 32'h603, 8'hFF);
    grant;
    #1;
    n_vec++; if ({burstSizeOUT, address_dataOUT} !== {8'd15, 32'h600}) begin n_err++; $display("FAIL clamp got=%h exp=%h", {burstSizeOUT, address_dataOUT}, {8'd15, 32'h600}); end
    tick;
    end_transactionIN = 1;
    tick;
    end_transactionIN = 0;
    #1;
    n_vec++; if ({done, error} !== 2'b10) begin n_err++; $display("FAIL clamp_done got=%b exp=10", {done, error}); end
    tick;
  endtask
  task automatic test_reset_mid_burst;
    issue(1, 32'h700, 3);
    fill(32'hC0, 4);
    grant;
    tick; tick; tick;
    #1;
    n_vec++; if (address_dataOUT !== 32'hC2) begin n_err++; $display("FAIL rm_word2 got=%h exp=%h", address_dataOUT, 32'hC2); end
    system_reset = 1;
    tick;
    system_reset = 0;
    #1;
    n_vec++; if ({cmd_ready, wdata_ready, done, error, request_out, begin_transactionOUT, end_transactionOUT, data_validOUT, read_n_writeOUT} !== 9'b100000000) begin n_err++; $display("FAIL rm_ctrl got=%b exp=100000000", {cmd_ready, wdata_ready, done, error, request_out, begin_transactionOUT, end_transactionOUT, data_validOUT, read_n_writeOUT}); end
    n_vec++; if ({address_dataOUT, byte_enablesOUT, burstSizeOUT} !== 44'h0) begin n_err++; $display("FAIL rm_data got=%h exp=0", {address_dataOUT, byte_enablesOUT, burstSizeOUT}); end
    issue(1, 32'h800, 1);
    fill(32'hD0, 2);
    grant;
    #1;
    n_vec++; if ({begin_transactionOUT, burstSizeOUT, address_dataOUT} !== {1'b1, 8'd1, 32'h800}) begin n_err++; $display("FAIL rm_begin got=%h exp=%h", {begin_transactionOUT, burstSizeOUT, address_dataOUT}, {1'b1, 8'd1, 32'h800}); end
    tick;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if ({data_validOUT, address_dataOUT} !== {1'b1, 32'hD0 + 32'(i)}) begin n_err++; $display("FAIL rm_data%0d got=%h exp=%h", i, {data_validOUT, address_dataOUT}, {1'b1, 32'hD0 + 32'(i)}); end
      tick;
    end
    #1;
    n_vec++; if (end_transactionOUT !== 1'b1) begin n_err++; $display("FAIL rm_end got=%b exp=1", end_transactionOUT); end
    tick; #1;
    n_vec++; if ({done, error} !== 2'b10) begin n_err++; $display("FAIL rm_done got=%b exp=10", {done, error}); end
    tick;
  endtask
  task automatic test_grant_reset;
    issue(0, 32'h900, 0);
    grant_in = 1; system_reset = 1;
    tick;
    grant_in = 0; system_reset = 0;
    #1;
    n_vec++; if ({request_out, begin_transactionOUT, cmd_ready} !== 3'b001) begin n_err++; $display("FAIL gr_reset got=%b exp=001", {request_out, begin_transactionOUT, cmd_ready}); end
  endtask
  initial begin
    test_reset;
    test_write;
    test_busy;
    test_read;
    test_read_error;
    test_timeout;
    test_write_error;
    test_clamp;
    test_reset_mid_burst;
    test_grant_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
